mealy_machine: RTL and testbench
================================

// Module: mealy_machine
// PURPOSE
//  Mealy serial sequence detector: samples 1-bit input j once per clk rising edge.
//  Output w asserts combinationally in the same cycle the final pattern bit is present on j.
//  Leaf block placed after a bit-serial source; w feeds downstream control logic.
// PARAMETERS
//  N        4         pattern length in bits, 2..8
//  PATTERN  4'b1010   target sequence; PATTERN[N-1] is received first, PATTERN[0] last
//  OVERLAP  1         1: matches may overlap; 0: state returns to S0 after a match
// PORTS
//  clk  in   1  single clock; all state updates on the rising edge
//  rst  in   1  reset, synchronous, active-high
//  j    in   1  serial data bit, sampled every rising clk edge
//  w    out  1  match flag, Mealy (combinational from state and j)
//  match_cnt out 8  matches counted since reset (present only with MEALY_MACHINE_CNT_EN)
// BEHAVIOUR
//  - State encodes the matched prefix length k = 0..N-1 (S0..S{N-1}). Width is $clog2(N).
//  - Reset: on a rising edge with rst=1, state <= S0 and j is ignored.
//    During reset, w = 0 unless the state is S{N-1}. With N>=2, w is 0 the cycle after reset.
//  - w = (state == S{N-1}) && (j == PATTERN[0]). It changes with j in the same cycle, with no register.
//  - Next state is the longest prefix of PATTERN that is a proper suffix of (matched prefix + j), i.e. a KMP failure function.
//    The transition table is computed at elaboration in a constant function.
//  - After a match: OVERLAP=1 goes to the longest proper border of PATTERN; OVERLAP=0 goes to S0.
//  - Default 1010 transitions (j=0 / j=1):
//    S0: S0 / S1
//    S1: S2 / S1
//    S2: S0 / S3
//    S3: w=1, ->S2 / ->S1
//  - j is X/Z while in S0, or rst is high: state stays S0, w stays 0 (X must not propagate).
//  - rst high mid-sequence discards the partial match. No match completes on the reset edge.
// CONFIGURATION
//  MEALY_MACHINE_CNT_EN defined:
//    Port match_cnt exists. It is cleared by rst.
//    It increments on each rising edge where w=1 and rst=0, and saturates at 8'hFF.
//  Undefined: match_cnt port absent; w behaviour is identical in both builds.
// STRUCTURE
//  Package mealy_machine_pkg:
//    - state typedef (logic [$clog2(N)-1:0])
//    - S0 constant
//    - constant function build_next(PATTERN,N,OVERLAP) returning the 2*N next-state table
//  Sub-module mealy_match_counter (8-bit saturating counter, clk/rst/inc/cnt).
//    Instantiated only under MEALY_MACHINE_CNT_EN.
//  Main module: state register + table lookup + output compare.
// TESTING
//  1 rst=1 two edges, then j=1,1,0,0,1,0,1,0,1,1,0 -> w=1 only on 8th bit; states S1,S1,S2,S0,S1,S2,S3,S3->S2,S3,S1,S2
//  2 overlap: j=1,0,1,0,1,0 -> w=1 on bits 4 and 6; with OVERLAP=0 -> w=1 on bit 4 only
//  3 reset mid-op: j=1,0,1 then rst=1 with j=0 -> w=0 after reset, state S0; then 0,1,0 -> no match
//  4 j=0 for 16 cycles, then j=1 for 16 cycles -> w stays 0, state S0 then S1
//  5 Mealy timing: in S3 toggle j 0->1 mid-cycle -> w follows 1->0 without waiting for a clk edge
//  6 CNT_EN: 300 back-to-back 1010 matches -> match_cnt ends at 8'hFF; rst -> 0

Source files
------------

// File: rtl/mealy_machine_pkg.sv
// +----------------------------------------------------------------------------+
// | mealy_machine_pkg                                                          |
// | Shared state type, idle constant and the KMP next-state table builder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mealy_machine_pkg;

  localparam int MAX_N   = 8;
  localparam int STATE_W = $clog2(MAX_N);

  typedef logic [STATE_W-1:0] state_t;
  typedef state_t [2*MAX_N-1:0] next_tbl_t;

  localparam state_t S0 = '0;

  // Entry 2*k+b holds the next state from prefix length k on input bit b.
  // The received stream is bit i = pattern[n-1-i], so prefixes read MSB first.
  function automatic next_tbl_t build_next(input logic [MAX_N-1:0] pattern,
                                           input int n, input bit overlap);
    next_tbl_t        tbl;
    logic [MAX_N:0]   s;
    int               m;
    int               best;
    bit               ok;
    tbl = '0;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 2; b++) begin
        m = k + 1;
        s = '0;
        for (int i = 0; i < k; i++) s[i] = pattern[n-1-i];
        s[k] = b[0];
        best = 0;
        if (k < n - 1 && b[0] == pattern[n-1-k]) begin
          best = k + 1;
        end else if (k == n - 1 && b[0] == pattern[0] && !overlap) begin
          best = 0;
        end else begin
          for (int l = m - 1; l >= 1; l--) begin
            if (best == 0) begin
              ok = 1'b1;
              for (int i = 0; i < l; i++) begin
                if (s[m-l+i] != pattern[n-1-i]) ok = 1'b0;
              end
              if (ok) best = l;
            end
          end
        end
        tbl[2*k+b] = state_t'(best);
      end
    end
    return tbl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mealy_match_counter.sv
// +----------------------------------------------------------------------------+
// | mealy_match_counter                                                        |
// | 8-bit saturating event counter with synchronous active-high clear.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mealy_match_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mealy_machine.sv
// +----------------------------------------------------------------------------+
// | mealy_machine                                                              |
// | Mealy serial sequence detector with KMP next-state table.                  |
// | Optional match counter enabled by MEALY_MACHINE_CNT_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mealy_machine
  import mealy_machine_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1010,
  parameter bit           OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       j,
  output logic       w
`ifdef MEALY_MACHINE_CNT_EN
  ,
  output logic [7:0] match_cnt
`endif
);

  localparam int            SW       = $clog2(N);
  localparam next_tbl_t     NEXT_TBL = build_next(MAX_N'(PATTERN), N, OVERLAP);
  localparam logic [SW-1:0] S_IDLE   = SW'(S0);
  localparam logic [SW-1:0] S_FIRST  = SW'(1);
  localparam logic [SW-1:0] S_LAST   = SW'(N - 1);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  // Idle advances only on an exact first-bit compare, so an unknown j keeps S0.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (j == PATTERN[N-1]) state_d = S_FIRST;
    end else if (j) begin
      state_d = SW'(NEXT_TBL[{STATE_W'(state_q), 1'b1}]);
    end else begin
      state_d = SW'(NEXT_TBL[{STATE_W'(state_q), 1'b0}]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign w = (state_q == S_LAST) && (j == PATTERN[0]);

`ifdef MEALY_MACHINE_CNT_EN
  mealy_match_counter u_match_counter (
    .clk (clk),
    .rst (rst),
    .inc (w & ~rst),
    .cnt (match_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_machine.sv
// +----------------------------------------------------------------------------+
// | tb_mealy_machine                                                           |
// | Self-checking bench: vector table, directed sequences, random vs model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mealy_machine;

  logic       clk;
  logic       rst;
  logic       j;
  logic [2:0] wv;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  int n_chk = 0;
  int n_err = 0;

  mealy_machine #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) dut0 (
    .clk(clk), .rst(rst), .j(j), .w(wv[0])
`ifdef MEALY_MACHINE_CNT_EN
    , .match_cnt(cnt0)
`endif
  );

  mealy_machine #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .j(j), .w(wv[1])
`ifdef MEALY_MACHINE_CNT_EN
    , .match_cnt(cnt1)
`endif
  );

  mealy_machine #(.N(5), .PATTERN(5'b11011), .OVERLAP(1'b1)) dut2 (
    .clk(clk), .rst(rst), .j(j), .w(wv[2])
`ifdef MEALY_MACHINE_CNT_EN
    , .match_cnt(cnt2)
`endif
  );

`ifndef MEALY_MACHINE_CNT_EN
  assign cnt0 = 8'h00;
  assign cnt1 = 8'h00;
  assign cnt2 = 8'h00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: w is 1 when the last N received bits (since reset, or since the
  // previous match when overlap is off) spell the pattern, first bit first.
  int         m_n   [3] = '{4, 4, 5};
  logic [7:0] m_pat [3] = '{8'h0A, 8'h0A, 8'h1B};
  bit         m_ov  [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_hist[3] = '{8'h00, 8'h00, 8'h00};
  int         m_len [3] = '{0, 0, 0};
  int         m_cnt     = 0;

  function automatic bit model_w(input int i, input logic jv);
    logic [8:0] s;
    logic [8:0] mask;
    s    = {m_hist[i], jv};
    mask = 9'((1 << m_n[i]) - 1);
    return (m_len[i] >= m_n[i] - 1) && ((s & mask) == {1'b0, m_pat[i]});
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic jv, input logic rv, input bit use_tbl,
                      input logic e0, input logic e1);
    bit mw[3];
    j   = jv;
    rst = rv;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mw[i] = model_w(i, jv);
      chk($sformatf("w_model[%0d]", i), {7'd0, wv[i]}, {7'd0, mw[i]});
    end
    if (use_tbl) begin
      chk("w_tbl_overlap", {7'd0, wv[0]}, {7'd0, e0});
      chk("w_tbl_nooverlap", {7'd0, wv[1]}, {7'd0, e1});
    end
`ifdef MEALY_MACHINE_CNT_EN
    chk("match_cnt_model", cnt0, 8'(m_cnt));
`endif
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rv) begin
        m_len[i] = 0;
      end else if (mw[i] && !m_ov[i]) begin
        m_len[i] = 0;
      end else begin
        m_hist[i] = {m_hist[i][6:0], jv};
        if (m_len[i] < 8) m_len[i]++;
      end
    end
    if (rv) m_cnt = 0;
    else if (mw[0] && m_cnt < 255) m_cnt++;
    #1;
  endtask

  typedef struct {
    logic j;
    logic rst;
    logic w_ov;
    logic w_no;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    j   = 1'b0;

    vecs = '{
      '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b0}
    };

    // Reset, single match, overlapping matches.
    for (int v = 0; v < 20; v++) step(vecs[v].j, vecs[v].rst, 1'b1, vecs[v].w_ov, vecs[v].w_no);

    // Reset in the middle of a pattern: w may show during the reset cycle
    // (state is S3, j=0) but the partial match must be gone afterwards.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Long runs of constant input never match.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Combinational output: toggle j inside one cycle while in S3.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    j = 1'b0; #1;
    chk("mealy_j0", {7'd0, wv[0]}, 8'd1);
    j = 1'b1; #1;
    chk("mealy_j1", {7'd0, wv[0]}, 8'd0);
    j = 1'b0; #1;
    chk("mealy_j0_again", {7'd0, wv[0]}, 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Random stream with occasional resets against the model.
    for (int c = 0; c < 500; c++) begin
      step(1'($urandom), ($urandom_range(0, 31) == 0), 1'b0, 1'b0, 1'b0);
    end

`ifdef MEALY_MACHINE_CNT_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("match_cnt_saturated", cnt0, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("match_cnt_after_rst", cnt0, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
